seg7_text_scroller: RTL and testbench
=====================================

// Module: seg7_text_scroller
// PURPOSE
//  Time-multiplexed, scrolling text driver for a common-anode NUM_DIGITS x 7-seg display.
//  - Holds a MSG_LEN-glyph message buffer, written through a simple write port.
//  - Scans one digit at a time.
//  - Shifts a NUM_DIGITS-wide window across the message, with an optional hold at wrap.
//  - Sits between the control logic that writes the message and the board's seg/anode pins.
// PARAMETERS
//  NUM_DIGITS  4   physical digits; 1 <= NUM_DIGITS <= MSG_LEN
//  MSG_LEN     8   message buffer depth in glyphs; >= 2
//  SCAN_DIV    1000   clk cycles per digit scan slot; >= 1
//  STEP_DIV    500    scan-slot terminals per scroll step; >= 1
//  HOLD_STEPS  2   step periods frozen after each wrap; 0 = no hold
// PORTS
//  clk       in   1            single clock, rising edge
//  reset     in   1            synchronous, active-high
//  run       in   1            1 = scrolling enabled; 0 = window frozen
//  wr_en     in   1            message write strobe
//  wr_addr   in   clog2(MSG_LEN)   buffer index; writes with wr_addr >= MSG_LEN are ignored
//  wr_data   in   4            glyph code
//  seg       out  7            {a,b,c,d,e,f,g}; active-high segment on
//  an        out  NUM_DIGITS   digit enable, active-low, one-hot-low
//  pos       out  clog2(MSG_LEN)   message index shown on digit 0
//  wrap      out  1            one-cycle pulse when pos goes MSG_LEN-1 -> 0
// BEHAVIOUR
//  Glyph table (code: seg):
//   0 r 0000101 | 1 u 0011100 | 2 b 0011111 | 3 i 0000100 | 4 S 1011011
//   5..15 blank 0000000
//  Reset (clk edge with reset=1; dominates every other input):
//   - buffer all = 5
//   - scan_cnt, step_cnt, hold_cnt, digit, pos = 0; FSM = IDLE
//   - seg = 0000000, an = all 1s, wrap = 0
//  Writes: buffer[wr_addr] <= wr_data on the edge with wr_en=1.
//   - Accepted in every state.
//   - Visible on seg from the next scan of the affected digit.
//  Scan:
//   - scan_cnt counts 0..SCAN_DIV-1, free-running, independent of run.
//   - At terminal: digit <= (digit == NUM_DIGITS-1) ? 0 : digit+1.
//   - idx = pos + digit; if idx >= MSG_LEN, idx -= MSG_LEN (single subtract suffices).
//   - seg, an are registered: an[digit]=0, others 1; seg = glyph(buffer[idx]).
//   - Latency: one clk after digit/pos/buffer change.
//  Scroll FSM (step_tick = scan terminal while step_cnt == STEP_DIV-1):
//   - step_cnt advances only on scan terminals.
//   - IDLE:   run=1 -> SCROLL. pos, step_cnt held.
//   - SCROLL: run=0 -> IDLE; step_cnt holds its value, not cleared.
//     On step_tick, pos <= pos+1 mod MSG_LEN.
//     If pos was MSG_LEN-1: wrap=1 for that one cycle; if HOLD_STEPS > 0, go to HOLD with hold_cnt=0.
//   - HOLD:   pos frozen.
//     Each step_tick increments hold_cnt; when hold_cnt reaches HOLD_STEPS-1 at a step_tick, go to SCROLL.
//     run=0 -> IDLE; hold_cnt is cleared.
//  Boundaries:
//   - run deasserted on the step_tick edge: the step is NOT taken.
//   - A write to buffer[idx] on the same edge seg is loaded: seg shows the old glyph this slot.
//   - MSG_LEN == NUM_DIGITS: window wraps every step.
//   - Mid-operation reset: all of the above reset values on the next edge; no partial scroll.
// TESTING (NUM_DIGITS=4, MSG_LEN=6, SCAN_DIV=2, STEP_DIV=4, HOLD_STEPS=2)
//  1. reset 3 cycles -> seg=0000000, an=1111, pos=0, wrap=0.
//     After release an cycles 1110,1101,1011,0111, each held 2 clk.
//  2. write codes 0,1,2,3,4,5 to addr 0..5, run=0
//     -> digits 0..3 show 0000101, 0011100, 0011111, 0000100; pos stays 0 for 200 clk.
//  3. run=1 -> pos increments every 8 clk.
//     At pos=2, digit 3 shows buffer[5] = blank, digit 0 shows 0011111.
//  4. run=1 through pos 5 -> pos=0 with a single-cycle wrap=1.
//     pos then holds for 16 clk (HOLD), then resumes with 8 clk/step.
//  5. drop run for 20 clk mid-step, then re-raise -> step completes after the remaining count only.
//     pos is unchanged while run=0.
//  6. reset asserted mid-HOLD with pending write -> reset values win.
//     Buffer all blank; wr_addr=7 write is ignored (no buffer entry changes).

Source files
------------

// File: rtl/seg7_text_scroller.sv
// Scrolling, time-multiplexed text driver for a common-anode multi-digit 7-segment display.
// A message buffer is scanned one digit at a time. A window NUM_DIGITS glyphs wide steps
// across the message and can pause for a few step periods after each wrap.
module seg7_text_scroller #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MSG_LEN    = 8,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned STEP_DIV   = 500,
  parameter int unsigned HOLD_STEPS = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       run_i,
  input  logic                       wr_en_i,
  input  logic [$clog2(MSG_LEN)-1:0] wr_addr_i,
  input  logic [3:0]                 wr_data_i,
  output logic [6:0]                 seg_o,
  output logic [NUM_DIGITS-1:0]      an_o,
  output logic [$clog2(MSG_LEN)-1:0] pos_o,
  output logic                       wrap_o
);

  localparam int unsigned AW = $clog2(MSG_LEN);
  localparam int unsigned IW = AW + 1;
  localparam int unsigned DW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCROLL,
    ST_HOLD
  } state_e;

  state_e                state_q, state_d;
  logic [SW-1:0]         scan_cnt_q, scan_cnt_d;
  logic [DW-1:0]         digit_q, digit_d;
  logic [TW-1:0]         step_cnt_q, step_cnt_d;
  logic [HW-1:0]         hold_cnt_q, hold_cnt_d;
  logic [AW-1:0]         pos_q, pos_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  wrap_q, wrap_d;
  logic [3:0]            msg_q [MSG_LEN];

  logic                  scan_term;
  logic                  step_last;
  logic                  step_tick;
  logic                  pos_last;
  logic                  hold_last;
  logic                  digit_last;
  logic                  step_en;
  logic                  pos_inc;
  logic [IW-1:0]         idx_sum;
  logic [AW-1:0]         rd_idx;

  // Glyph code to {a,b,c,d,e,f,g}; unused codes are blank.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    return 7'b0000101;
      4'd1:    return 7'b0011100;
      4'd2:    return 7'b0011111;
      4'd3:    return 7'b0000100;
      4'd4:    return 7'b1011011;
      default: return 7'b0000000;
    endcase
  endfunction

  // Terminal-count decodes shared by the scan, step and hold logic.
  always_comb begin
    scan_term  = (scan_cnt_q == SW'(SCAN_DIV - 1));
    step_last  = (step_cnt_q == TW'(STEP_DIV - 1));
    step_tick  = scan_term & step_last;
    pos_last   = (pos_q == AW'(MSG_LEN - 1));
    hold_last  = (hold_cnt_q == HW'(HOLD_STEPS - 1));
    digit_last = (digit_q == DW'(NUM_DIGITS - 1));
  end

  // Scroll FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Scroll FSM next state. Dropping run always wins over a coincident step_tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (run_i) state_d = ST_SCROLL;
      end
      ST_SCROLL: begin
        if (!run_i) state_d = ST_IDLE;
        else if (step_tick && pos_last && (HOLD_STEPS != 0)) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (!run_i) state_d = ST_IDLE;
        else if (step_tick && hold_last) state_d = ST_SCROLL;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scroll FSM outputs: step counter enable, window advance, wrap pulse and hold count.
  always_comb begin
    step_en    = 1'b0;
    pos_inc    = 1'b0;
    wrap_d     = 1'b0;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      ST_SCROLL: begin
        if (run_i) begin
          step_en = 1'b1;
          if (step_tick) begin
            pos_inc = 1'b1;
            if (pos_last) begin
              wrap_d     = 1'b1;
              hold_cnt_d = '0;
            end
          end
        end
      end
      ST_HOLD: begin
        if (!run_i) begin
          hold_cnt_d = '0;
        end else begin
          step_en = 1'b1;
          if (step_tick) hold_cnt_d = hold_last ? '0 : hold_cnt_q + HW'(1);
        end
      end
      default: ;
    endcase
  end

  // Next values for the counters, window position and the registered display outputs.
  always_comb begin
    scan_cnt_d = scan_term ? '0 : scan_cnt_q + SW'(1);
    digit_d    = digit_q;
    if (scan_term) digit_d = digit_last ? '0 : digit_q + DW'(1);
    step_cnt_d = step_cnt_q;
    if (step_en && scan_term) step_cnt_d = step_last ? '0 : step_cnt_q + TW'(1);
    pos_d = pos_q;
    if (pos_inc) pos_d = pos_last ? '0 : pos_q + AW'(1);
    // pos + digit stays below 2*MSG_LEN, so one conditional subtract wraps it.
    idx_sum = IW'(pos_q) + IW'(digit_q);
    if (32'(idx_sum) >= MSG_LEN) idx_sum = idx_sum - IW'(MSG_LEN);
    rd_idx = AW'(idx_sum);
    seg_d  = glyph(msg_q[rd_idx]);
    an_d   = ~(NUM_DIGITS'(1) << digit_q);
  end

  // Counter, window and display output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      pos_q      <= '0;
      seg_q      <= '0;
      an_q       <= '1;
      wrap_q     <= 1'b0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pos_q      <= pos_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
      wrap_q     <= wrap_d;
    end
  end

  // Message buffer; out-of-range addresses are dropped.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < MSG_LEN; i++) msg_q[i] <= 4'd5;
    end else if (wr_en_i && (32'(wr_addr_i) < MSG_LEN)) begin
      msg_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign seg_o  = seg_q;
  assign an_o   = an_q;
  assign pos_o  = pos_q;
  assign wrap_o = wrap_q;

endmodule

// File: tb/tb_seg7_text_scroller.sv
// Directed bench for seg7_text_scroller: 4 digits, 6-glyph message, 2 clk per scan slot,
// 4 slots per step, 2-step hold after wrap.
module tb_seg7_text_scroller;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [3:0] wr_data;
  logic [6:0] seg;
  logic [3:0] an;
  logic [2:0] pos;
  logic       wrap;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2:0] pos;
    int         digit;
    logic [6:0] seg;
  } vec_t;

  vec_t vecs[16];

  seg7_text_scroller #(
    .NUM_DIGITS(4), .MSG_LEN(6), .SCAN_DIV(2), .STEP_DIV(4), .HOLD_STEPS(2)
  ) dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .run_i    (run),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .seg_o    (seg),
    .an_o     (an),
    .pos_o    (pos),
    .wrap_o   (wrap)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Wait for the scan to reach digit d, then compare its segments.
  task automatic check_digit(input int d, input logic [6:0] exp_seg, input string name);
    logic [3:0] one;
    logic [3:0] want;
    bit found;
    one   = 4'b0001;
    want  = ~(one << d);
    found = 0;
    for (int i = 0; i < 16 && !found; i++) begin
      if (an == want) found = 1;
      else tick();
    end
    if (!found) check({name, " an timeout"}, 32'(an), 32'(want));
    else        check(name, 32'(seg), 32'(exp_seg));
  endtask

  task automatic wait_pos(input logic [2:0] target, input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (pos == target) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_wrap(input int limit, output int n);
    n = -1;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (wrap) begin
        n = i;
        break;
      end
    end
  endtask

  // Move the window to the vector's position (then freeze it) and check one digit.
  task automatic apply_vec(input int i);
    int n;
    if (pos != vecs[i].pos) begin
      run = 1'b1;
      wait_pos(vecs[i].pos, 60, n);
      if (n < 0) check("goto pos timeout", 32'(pos), 32'(vecs[i].pos));
      run = 1'b0;
      tick();
      tick();
    end
    check_digit(vecs[i].digit, vecs[i].seg, $sformatf("pos%0d digit%0d", vecs[i].pos, vecs[i].digit));
  endtask

  initial begin
    int n;
    int cnt;
    bit stay;
    logic [3:0] one;
    logic [3:0] exp_an;
    logic [3:0] prev_an;
    bit found;

    vecs[0]  = '{3'd0, 0, 7'b0000101};
    vecs[1]  = '{3'd0, 1, 7'b0011100};
    vecs[2]  = '{3'd0, 2, 7'b0011111};
    vecs[3]  = '{3'd0, 3, 7'b0000100};
    vecs[4]  = '{3'd2, 0, 7'b0011111};
    vecs[5]  = '{3'd2, 1, 7'b0000100};
    vecs[6]  = '{3'd2, 2, 7'b1011011};
    vecs[7]  = '{3'd2, 3, 7'b0000000};
    vecs[8]  = '{3'd4, 0, 7'b1011011};
    vecs[9]  = '{3'd4, 1, 7'b0000000};
    vecs[10] = '{3'd4, 2, 7'b0000101};
    vecs[11] = '{3'd4, 3, 7'b0011100};
    vecs[12] = '{3'd5, 0, 7'b0000000};
    vecs[13] = '{3'd5, 1, 7'b0000101};
    vecs[14] = '{3'd5, 2, 7'b0011100};
    vecs[15] = '{3'd5, 3, 7'b0011111};

    reset = 1'b1; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

    // Reset values, then the anode scan sequence with 2 clk per digit.
    repeat (3) tick();
    check("reset seg", 32'(seg), 32'(7'b0000000));
    check("reset an", 32'(an), 32'(4'b1111));
    check("reset pos", 32'(pos), 32'(0));
    check("reset wrap", 32'(wrap), 32'(0));
    reset = 1'b0;
    one = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      exp_an = ~(one << (((k - 1) / 2) % 4));
      check($sformatf("an scan %0d", k), 32'(an), 32'(exp_an));
    end
    check("blank after reset", 32'(seg), 32'(7'b0000000));

    // Load the message with run low; the window must stay put.
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 4'(i);
      tick();
    end
    wr_en = 1'b0;
    stay = 1;
    repeat (200) begin
      tick();
      if (pos != 3'd0) stay = 0;
    end
    check("pos frozen 200 clk", 32'(stay), 32'(1));

    for (int i = 0; i < 4; i++) apply_vec(i);

    // Steady scroll rate.
    run = 1'b1;
    wait_pos(3'd1, 20, n);
    check("first step seen", 32'(n >= 0), 32'(1));
    wait_pos(3'd2, 20, n);
    check("step period", 32'(n), 32'(8));
    run = 1'b0;
    tick();
    tick();

    for (int i = 4; i < 16; i++) apply_vec(i);

    // Wrap from pos 5: single-cycle pulse, 16 clk hold, then the normal 8 clk step.
    run = 1'b1;
    wait_wrap(20, n);
    check("wrap seen", 32'(n >= 0), 32'(1));
    check("pos at wrap", 32'(pos), 32'(0));
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      cnt++;
      if (cnt == 1) check("wrap one cycle", 32'(wrap), 32'(0));
      if (pos != 3'd0) break;
    end
    check("hold plus step length", 32'(cnt), 32'(24));
    check("pos after hold", 32'(pos), 32'(1));
    wait_pos(3'd2, 20, n);
    check("step after hold", 32'(n), 32'(8));

    // Pause mid-step for 20 clk: only the remaining 6 clk of the step are needed afterwards.
    tick();
    tick();
    run = 1'b0;
    stay = 1;
    repeat (20) begin
      tick();
      if (pos != 3'd2) stay = 0;
    end
    check("pos frozen while paused", 32'(stay), 32'(1));
    run = 1'b1;
    wait_pos(3'd3, 20, n);
    check("remaining step after pause", 32'(n), 32'(6));

    // Drop run on the step_tick edge: the step is not taken.
    repeat (7) tick();
    run = 1'b0;
    tick();
    check("no step when run drops on tick", 32'(pos), 32'(3));
    run = 1'b1;
    wait_pos(3'd4, 10, n);
    check("pending tick after re-raise", 32'(n), 32'(2));

    // Reset in the middle of HOLD with a write on the same edge.
    wait_wrap(40, n);
    check("second wrap time", 32'(n), 32'(16));
    repeat (4) tick();
    check("pos in hold", 32'(pos), 32'(0));
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 4'd4;
    tick();
    check("mid reset seg", 32'(seg), 32'(7'b0000000));
    check("mid reset an", 32'(an), 32'(4'b1111));
    check("mid reset pos", 32'(pos), 32'(0));
    check("mid reset wrap", 32'(wrap), 32'(0));
    reset = 1'b0; run = 1'b0; wr_addr = 3'd7; wr_data = 4'd4;
    tick();
    wr_en = 1'b0;
    for (int d = 0; d < 4; d++) check_digit(d, 7'b0000000, $sformatf("blank after reset digit%0d", d));

    // Write digit 0's glyph on its second load edge: this slot still shows the old glyph.
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      prev_an = an;
      tick();
      if (an == 4'b1110 && prev_an != 4'b1110) found = 1;
    end
    check("digit0 slot start found", 32'(found), 32'(1));
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 4'd0;
    tick();
    wr_en = 1'b0;
    check("same-edge write an", 32'(an), 32'(4'b1110));
    check("same-edge write old glyph", 32'(seg), 32'(7'b0000000));
    tick();
    check_digit(0, 7'b0000101, "new glyph next slot");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
